// File: rtl/popcount_stream.sv
// rtl/popcount_stream.sv - buffered, chunked ones/zeros counter with saturating running total
// Words queue in a small FIFO; the engine counts CHUNK_WIDTH bits per cycle.
module popcount_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [DATA_WIDTH-1:0]            WRITE_DATA,
  input  logic                             WRITE_VALID,
  output logic                             WRITE_READY,
  input  logic                             MODE,
  output logic [COUNT_WIDTH-1:0]           COUNT,
  input  logic                             COUNT_RST,
  output logic                             COUNT_BUSY,
  output logic                             COUNT_SAT,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  FIFO_LEVEL
);

  localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PC_W   = $clog2(CHUNK_WIDTH + 1);
  localparam int SUM_W  = COUNT_WIDTH + 1;

  typedef enum logic {IDLE, RUN} state_t;

  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_mode;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      chunk_cnt;
  logic [COUNT_WIDTH-1:0] total;
  logic                  sat;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_word;
  logic [PC_W-1:0]       chunk_ones;
  logic [SUM_W-1:0]      sum;

  assign full        = (level == LVL_W'(FIFO_DEPTH));
  assign empty       = (level == '0);
  assign WRITE_READY = !full && !COUNT_RST && !ARESET;
  assign push        = WRITE_VALID && WRITE_READY;
  // The engine takes a new word when idle or on the last chunk of the current one.
  assign pop         = !empty && ((state == IDLE) || (chunk_cnt == '0));
  assign head_word   = fifo_mode[rd_ptr] ? ~fifo_data[rd_ptr] : fifo_data[rd_ptr];

  always_comb begin
    chunk_ones = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_ones = chunk_ones + PC_W'(shreg[i]);
    end
    sum = {1'b0, total} + SUM_W'(chunk_ones);
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_data[wr_ptr] <= WRITE_DATA;
      fifo_mode[wr_ptr] <= MODE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || COUNT_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || COUNT_RST) begin
      state     <= IDLE;
      shreg     <= '0;
      chunk_cnt <= '0;
      total     <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= head_word;
            chunk_cnt <= CNT_W'(NCHUNK - 1);
            state     <= RUN;
          end
        end
        RUN: begin
          // Once saturated the total is pinned at all-ones until cleared.
          if (sat || sum[COUNT_WIDTH]) begin
            total <= '1;
            sat   <= 1'b1;
          end else begin
            total <= sum[COUNT_WIDTH-1:0];
          end
          shreg     <= shreg >> CHUNK_WIDTH;
          chunk_cnt <= chunk_cnt - 1'b1;
          if (chunk_cnt == '0) begin
            if (pop) begin
              shreg     <= head_word;
              chunk_cnt <= CNT_W'(NCHUNK - 1);
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign COUNT      = total;
  assign COUNT_SAT  = sat;
  assign COUNT_BUSY = !empty || (state == RUN);
  assign FIFO_LEVEL = level;

endmodule

// File: tb/tb_popcount_stream.sv
// tb/tb_popcount_stream.sv - scoreboard bench for popcount_stream
// Driver queues each accepted word's count; the monitor settles it when BUSY falls.
module tb_popcount_stream;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] write_data;
  logic        write_valid;
  logic        write_ready;
  logic        mode;
  logic [31:0] count;
  logic        count_rst;
  logic        count_busy;
  logic        count_sat;
  logic [2:0]  fifo_level;

  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_mode;
  logic [7:0]  s_count;
  logic        s_rst;
  logic        s_busy;
  logic        s_sat;
  logic [2:0]  s_level;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];
  longint unsigned model_total = 0;
  bit model_sat = 0;
  bit prev_busy = 0;

  always #5 aclk = ~aclk;

  popcount_stream dut (
    .ACLK(aclk), .ARESET(areset), .WRITE_DATA(write_data), .WRITE_VALID(write_valid),
    .WRITE_READY(write_ready), .MODE(mode), .COUNT(count), .COUNT_RST(count_rst),
    .COUNT_BUSY(count_busy), .COUNT_SAT(count_sat), .FIFO_LEVEL(fifo_level)
  );

  popcount_stream #(.COUNT_WIDTH(8)) dut_sat (
    .ACLK(aclk), .ARESET(areset), .WRITE_DATA(s_data), .WRITE_VALID(s_valid),
    .WRITE_READY(s_ready), .MODE(s_mode), .COUNT(s_count), .COUNT_RST(s_rst),
    .COUNT_BUSY(s_busy), .COUNT_SAT(s_sat), .FIFO_LEVEL(s_level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int unsigned contribution(input logic [31:0] w, input logic m);
    return m ? 32 - $countones(w) : $countones(w);
  endfunction

  // Scoreboard monitor: every accepted word has been counted once BUSY drops.
  always @(negedge aclk) begin
    if (!areset) begin
      if (prev_busy && !count_busy) begin
        while (exp_q.size() > 0) begin
          model_total = model_total + exp_q.pop_front();
          if (model_total > 64'hFFFF_FFFF) begin
            model_total = 64'hFFFF_FFFF;
            model_sat = 1;
          end
        end
        check("count_total", count, model_total);
        check("count_sat", count_sat, model_sat);
      end
      prev_busy = count_busy;
    end else begin
      prev_busy = 0;
    end
  end

  task automatic write_word(input logic [31:0] w, input logic m);
    bit rdy;
    bit done = 0;
    write_data = w;
    mode = m;
    write_valid = 1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      rdy = write_ready;
      @(posedge aclk);
      if (rdy) begin
        exp_q.push_back(contribution(w, m));
        done = 1;
      end
      #1;
    end
    write_valid = 0;
    if (!done) check("write_timeout", 0, 1);
  endtask

  task automatic do_rst();
    count_rst = 1;
    write_valid = 1;
    write_data = 32'hFFFF_FFFF;
    mode = 0;
    @(negedge aclk);
    check("ready_during_rst", write_ready, 0);
    @(posedge aclk);
    exp_q.delete();
    model_total = 0;
    model_sat = 0;
    #1;
    count_rst = 0;
    write_valid = 0;
    @(negedge aclk);
    check("rst_count", count, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", count_busy, 0);
    check("rst_sat", count_sat, 0);
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge aclk);
      if (!count_busy) done = 1;
      @(posedge aclk);
      #1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int accepted;
    bit saw_full;
    bit rdy;
    bit done;
    logic [31:0] w;

    areset = 1; write_data = 0; write_valid = 0; mode = 0; count_rst = 0;
    s_data = 0; s_valid = 0; s_mode = 0; s_rst = 0;
    repeat (2) @(posedge aclk);
    #1;
    check("reset_ready_low", write_ready, 0);
    check("reset_count", count, 0);
    check("reset_busy", count_busy, 0);
    check("reset_level", fifo_level, 0);
    check("reset_sat", count_sat, 0);
    areset = 0;
    #1;
    check("ready_after_reset", write_ready, 1);

    // Ones count across two words.
    write_word(32'hFFFF_FFFF, 0);
    write_word(32'h0000_000F, 0);
    wait_idle();
    check("two_words_count", count, 36);

    // Zeros count and pop-to-done latency from an idle block.
    do_rst();
    write_word(32'h0000_00FF, 1);
    n = 0;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge aclk);
      if (!count_busy) done = 1;
      else begin
        n++;
        @(posedge aclk);
      end
    end
    check("busy_latency_edges", n, 5);
    check("zero_count", count, 24);
    @(posedge aclk);
    #1;

    // Held VALID fills the FIFO; every word must be counted exactly once.
    do_rst();
    accepted = 0;
    saw_full = 0;
    write_data = 32'h0000_0001;
    mode = 0;
    write_valid = 1;
    for (int i = 0; i < 100 && accepted < 6; i++) begin
      @(negedge aclk);
      rdy = write_ready;
      if (!rdy && fifo_level == 3'd4) saw_full = 1;
      @(posedge aclk);
      if (rdy) begin
        accepted++;
        exp_q.push_back(1);
      end
      #1;
    end
    write_valid = 0;
    check("burst_accepted", accepted, 6);
    check("burst_saw_full", saw_full, 1);
    wait_idle();
    check("burst_count", count, 6);

    // Clear in the middle of a word, then count again.
    do_rst();
    write_word(32'hFFFF_FFFF, 0);
    repeat (2) @(posedge aclk);
    #1;
    do_rst();
    write_word(32'h0000_0003, 0);
    wait_idle();
    check("after_midword_rst", count, 2);

    // Randomised words, modes and gaps.
    do_rst();
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: w = 32'hFFFF_FFFF;
        1: w = 32'h0;
        default: w = $urandom;
      endcase
      write_word(w, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 6)) @(posedge aclk);
      #1;
    end
    wait_idle();
    check("random_queue_drained", exp_q.size(), 0);
    check("random_final_count", count, model_total);
    check("random_no_sat", count_sat, 0);

    // Saturation with an 8-bit total: 9 x 32 ones clamps to 255.
    accepted = 0;
    s_data = 32'hFFFF_FFFF;
    s_mode = 0;
    s_valid = 1;
    for (int i = 0; i < 200 && accepted < 9; i++) begin
      @(negedge aclk);
      rdy = s_ready;
      @(posedge aclk);
      if (rdy) accepted++;
      #1;
    end
    s_valid = 0;
    check("sat_accepted", accepted, 9);
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge aclk);
      if (!s_busy) done = 1;
      @(posedge aclk);
      #1;
    end
    check("sat_idle", done, 1);
    check("sat_count", s_count, (9 * 32 > 255) ? 255 : 9 * 32);
    check("sat_flag", s_sat, 1);
    s_rst = 1;
    @(posedge aclk);
    #1;
    s_rst = 0;
    @(negedge aclk);
    check("sat_rst_count", s_count, 0);
    check("sat_rst_flag", s_sat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
